// File: rtl/fc_argmax_stage.sv
// Argmax over the FC layer's signed output vector, one element per clock; ARGMAX_TIE_LAST_EN picks the highest index on ties.
// Latency: done pulses in the cycle after edge k+IN_SIZE-1 for a start sampled at edge k; result held until the next start.
// Backpressure: none; start is ignored while scanning and accepted in IDLE or DONE, so re-pulsing in DONE streams results.
module fc_argmax_stage #(
    parameter int IN_SIZE = 8,
    parameter int W       = 8,
    localparam int IDX_W  = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic signed [W*IN_SIZE-1:0] in_vector_flat,
    output logic        [IDX_W-1:0]     max_index,
    output logic signed [W-1:0]         max_value,
    output logic                        busy,
    output logic                        done,
    output logic                        result_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_SIZE - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    state_t                  state_q;
    logic [W*IN_SIZE-1:0]    vec_q;
    logic [IDX_W-1:0]        cnt_q;
    logic [IDX_W-1:0]        idx_q;
    logic signed [W-1:0]     val_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    rv_q;

    logic signed [W-1:0]     elem_d;
    logic                    take_d;

    assign elem_d = vec_q[int'(cnt_q)*W +: W];

`ifdef ARGMAX_TIE_LAST_EN
    assign take_d = (elem_d >= val_q);
`else
    assign take_d = (elem_d > val_q);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            val_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        vec_q <= in_vector_flat;
                        val_q <= in_vector_flat[W-1:0];
                        idx_q <= '0;
                        cnt_q <= ONE_IDX;
                        // A single element is already the answer: skip the scan entirely.
                        if (IN_SIZE == 1) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            rv_q    <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_SCAN;
                            rv_q    <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_SCAN: begin
                    if (take_d) begin
                        val_q <= elem_d;
                        idx_q <= cnt_q;
                    end
                    if (cnt_q == LAST_IDX) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        rv_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + ONE_IDX;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign max_index    = idx_q;
    assign max_value    = val_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result_valid = rv_q;

endmodule
